// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port data memory between two MEM-stage
// lanes. Lane A (older) wins a same-cycle conflict; lane B's request is
// parked in a one-entry skid buffer and issued on the following cycle,
// which stalls both lanes for exactly that one cycle.
module dmem_arbiter #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_valid,
  input  logic [1:0]        a_mem_sig,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  input  logic              b_valid,
  input  logic [1:0]        b_mem_sig,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              lanes_ready,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic [1:0]        mem_sig,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [CNT_W-1:0]  conflict_cnt
);

  localparam logic [1:0] SIG_NONE  = 2'b00;
  localparam logic [1:0] SIG_READ  = 2'b01;
  localparam logic [1:0] SIG_WRITE = 2'b10;

  typedef enum logic {
    ST_EMPTY,
    ST_HELD
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_A,
    OWN_B
  } owner_t;

  state_t              state_reg, state_next;
  owner_t              rd_owner_reg, rd_owner_next;
  logic [1:0]          skid_sig_reg, skid_sig_next;
  logic [ADDR_W-1:0]   skid_addr_reg, skid_addr_next;
  logic [DATA_W-1:0]   skid_wdata_reg, skid_wdata_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;

  logic a_active;
  logic b_active;

  // A request only counts when valid and carrying a real READ or WRITE;
  // encoding 11 behaves exactly like NONE.
  assign a_active = a_valid && ((a_mem_sig == SIG_READ) || (a_mem_sig == SIG_WRITE));
  assign b_active = b_valid && ((b_mem_sig == SIG_READ) || (b_mem_sig == SIG_WRITE));

  // Next-state, issue selection and memory-side drive.
  always_comb begin
    state_next      = state_reg;
    rd_owner_next   = OWN_NONE;
    skid_sig_next   = skid_sig_reg;
    skid_addr_next  = skid_addr_reg;
    skid_wdata_next = skid_wdata_reg;
    cnt_next        = cnt_reg;
    lanes_ready     = 1'b1;
    mem_sig         = SIG_NONE;
    mem_addr        = '0;
    mem_wdata       = '0;

    unique case (state_reg)
      ST_EMPTY: begin
        if (a_active) begin
          mem_sig   = a_mem_sig;
          mem_addr  = a_addr;
          mem_wdata = (a_mem_sig == SIG_WRITE) ? a_wdata : '0;
          if (a_mem_sig == SIG_READ) rd_owner_next = OWN_A;
          if (b_active) begin
            // Accept B now but issue it next cycle, keeping program order.
            state_next      = ST_HELD;
            skid_sig_next   = b_mem_sig;
            skid_addr_next  = b_addr;
            skid_wdata_next = b_wdata;
            if (cnt_reg != '1) cnt_next = cnt_reg + CNT_W'(1);
          end
        end else if (b_active) begin
          mem_sig   = b_mem_sig;
          mem_addr  = b_addr;
          mem_wdata = (b_mem_sig == SIG_WRITE) ? b_wdata : '0;
          if (b_mem_sig == SIG_READ) rd_owner_next = OWN_B;
        end
      end
      ST_HELD: begin
        // Drain the parked B request; lanes must hold their inputs.
        lanes_ready     = 1'b0;
        mem_sig         = skid_sig_reg;
        mem_addr        = skid_addr_reg;
        mem_wdata       = (skid_sig_reg == SIG_WRITE) ? skid_wdata_reg : '0;
        if (skid_sig_reg == SIG_READ) rd_owner_next = OWN_B;
        state_next      = ST_EMPTY;
        skid_sig_next   = SIG_NONE;
        skid_addr_next  = '0;
        skid_wdata_next = '0;
      end
      default: begin
        state_next = ST_EMPTY;
      end
    endcase

    // While reset is asserted nothing may reach the memory, even if the
    // lanes are still presenting requests.
    if (!rst_n) begin
      lanes_ready = 1'b1;
      mem_sig     = SIG_NONE;
      mem_addr    = '0;
      mem_wdata   = '0;
    end
  end

  // State, skid buffer, read owner and conflict counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_EMPTY;
      rd_owner_reg   <= OWN_NONE;
      skid_sig_reg   <= SIG_NONE;
      skid_addr_reg  <= '0;
      skid_wdata_reg <= '0;
      cnt_reg        <= '0;
    end else begin
      state_reg      <= state_next;
      rd_owner_reg   <= rd_owner_next;
      skid_sig_reg   <= skid_sig_next;
      skid_addr_reg  <= skid_addr_next;
      skid_wdata_reg <= skid_wdata_next;
      cnt_reg        <= cnt_next;
    end
  end

  // Route the memory's registered read data to whichever lane issued the read.
  assign a_rvalid     = (rd_owner_reg == OWN_A);
  assign b_rvalid     = (rd_owner_reg == OWN_B);
  assign a_rdata      = a_rvalid ? mem_rdata : '0;
  assign b_rdata      = b_rvalid ? mem_rdata : '0;
  assign conflict_cnt = cnt_reg;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a simple data memory, a cycle-level behavioural
// model (pending-B slot, golden memory, expected read return) compared on
// every falling edge, directed scenarios with literal expectations, then
// randomized traffic.
module tb_dmem_arbiter;

  localparam int AW = 14;
  localparam int DW = 32;
  localparam int CW = 4;
  localparam logic [1:0] RD = 2'b01;
  localparam logic [1:0] WR = 2'b10;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          a_valid, b_valid;
  logic [1:0]    a_mem_sig, b_mem_sig;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wdata, b_wdata;
  logic          lanes_ready;
  logic          a_rvalid, b_rvalid;
  logic [DW-1:0] a_rdata, b_rdata;
  logic [1:0]    mem_sig;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic [CW-1:0] conflict_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_mem_sig(a_mem_sig), .a_addr(a_addr), .a_wdata(a_wdata),
    .b_valid(b_valid), .b_mem_sig(b_mem_sig), .b_addr(b_addr), .b_wdata(b_wdata),
    .lanes_ready(lanes_ready),
    .a_rvalid(a_rvalid), .a_rdata(a_rdata), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .mem_sig(mem_sig), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  // Environment data memory: registered read, zero on non-read cycles.
  logic [DW-1:0] env_mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (mem_sig == WR) env_mem[mem_addr] <= mem_wdata;
    mem_rdata <= (mem_sig == RD) ? env_mem[mem_addr] : '0;
  end

  // Behavioural model state.
  logic [DW-1:0] gold [0:(1<<AW)-1];
  bit            m_pend;
  logic [1:0]    m_pend_sig;
  logic [AW-1:0] m_pend_addr;
  logic [DW-1:0] m_pend_wd;
  int            m_owner;      // 0 none, 1 lane A, 2 lane B
  logic [DW-1:0] m_ret;
  int            m_cnt;
  bit            m_ready = 1'b1;
  logic [1:0]    e_sig;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wd;
  bit            e_ready;
  int            e_lane;
  bit            a_act, b_act;

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      env_mem[i] = i * 32'h9E3779B9;
      gold[i]    = i * 32'h9E3779B9;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Per-cycle compare against the model; the model advances one cycle here
  // (inputs and reset only change just after the rising edge).
  always @(negedge clk) begin
    if (!rst_n) begin
      m_pend  = 1'b0;
      m_owner = 0;
      m_cnt   = 0;
      m_ready = 1'b1;
      chk("rst_ready", lanes_ready, 1);
      chk("rst_mem_sig", mem_sig, 0);
      chk("rst_a_rvalid", a_rvalid, 0);
      chk("rst_b_rvalid", b_rvalid, 0);
      chk("rst_a_rdata", a_rdata, 0);
      chk("rst_b_rdata", b_rdata, 0);
      chk("rst_cnt", conflict_cnt, 0);
    end else begin
      chk("a_rvalid", a_rvalid, m_owner == 1);
      chk("b_rvalid", b_rvalid, m_owner == 2);
      chk("a_rdata", a_rdata, (m_owner == 1) ? m_ret : 32'h0);
      chk("b_rdata", b_rdata, (m_owner == 2) ? m_ret : 32'h0);
      chk("cnt", conflict_cnt, m_cnt);

      e_sig = 2'b00; e_addr = '0; e_wd = '0; e_lane = 0;
      a_act = a_valid && (a_mem_sig == RD || a_mem_sig == WR);
      b_act = b_valid && (b_mem_sig == RD || b_mem_sig == WR);
      if (m_pend) begin
        e_ready = 1'b0;
        e_sig = m_pend_sig; e_addr = m_pend_addr; e_wd = m_pend_wd; e_lane = 2;
        m_pend = 1'b0;
      end else begin
        e_ready = 1'b1;
        if (a_act) begin
          e_sig = a_mem_sig; e_addr = a_addr; e_wd = a_wdata; e_lane = 1;
          if (b_act) begin
            m_pend = 1'b1;
            m_pend_sig = b_mem_sig; m_pend_addr = b_addr; m_pend_wd = b_wdata;
            if (m_cnt < (1 << CW) - 1) m_cnt++;
          end
        end else if (b_act) begin
          e_sig = b_mem_sig; e_addr = b_addr; e_wd = b_wdata; e_lane = 2;
        end
      end
      if (e_sig != WR) e_wd = '0;

      chk("ready", lanes_ready, e_ready);
      chk("mem_sig", mem_sig, e_sig);
      chk("mem_addr", mem_addr, e_addr);
      chk("mem_wdata", mem_wdata, e_wd);

      m_owner = 0;
      if (e_sig == RD) begin
        m_owner = e_lane;
        m_ret   = gold[e_addr];
      end else if (e_sig == WR) begin
        gold[e_addr] = e_wd;
      end
      m_ready = e_ready;
      if (e_sig != 2'b00)
        $display("txn t=%0t lane=%s op=%s addr=%h data=%h", $time,
                 (e_lane == 1) ? "A" : "B", (e_sig == RD) ? "RD" : "WR",
                 e_addr, (e_sig == RD) ? m_ret : e_wd);
    end
  end

  task automatic idle();
    a_valid = 1'b0; a_mem_sig = 2'b00; a_addr = '0; a_wdata = '0;
    b_valid = 1'b0; b_mem_sig = 2'b00; b_addr = '0; b_wdata = '0;
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  // Present a request pair and keep it until the model says it was accepted.
  task automatic step(input bit av, input logic [1:0] as, input logic [AW-1:0] aa,
                      input logic [DW-1:0] aw, input bit bv, input logic [1:0] bs,
                      input logic [AW-1:0] ba, input logic [DW-1:0] bw);
    a_valid = av; a_mem_sig = as; a_addr = aa; a_wdata = aw;
    b_valid = bv; b_mem_sig = bs; b_addr = ba; b_wdata = bw;
    cyc();
    for (int k = 0; k < 3 && !m_ready; k++) cyc();
    if (!m_ready) chk("accept_bound", m_ready, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    idle();
    repeat (3) cyc();
    rst_n = 1'b1;
    cyc();

    // Lane A alone: write then read back.
    step(1, WR, 14'h0010, 32'hDEADBEEF, 0, 2'b00, '0, '0);
    step(1, RD, 14'h0010, '0, 0, 2'b00, '0, '0);
    chk("t1_a_rvalid", a_rvalid, 1);
    chk("t1_a_rdata", a_rdata, 32'hDEADBEEF);
    chk("t1_b_rvalid", b_rvalid, 0);
    idle(); cyc(); cyc();

    // Conflict: A writes, B reads the same address.
    step(1, WR, 14'h0020, 32'h11111111, 1, RD, 14'h0020, '0);
    idle(); #1;
    chk("t2_stall", lanes_ready, 0);
    chk("t2_cnt", conflict_cnt, 1);
    cyc();
    chk("t2_b_rvalid", b_rvalid, 1);
    chk("t2_b_rdata", b_rdata, 32'h11111111);
    chk("t2_a_rvalid", a_rvalid, 0);
    cyc();

    // Conflict: A reads old data, B writes new data.
    step(1, WR, 14'h0030, 32'h5, 0, 2'b00, '0, '0);
    step(1, RD, 14'h0030, '0, 1, WR, 14'h0030, 32'hABCD0123);
    chk("t3_a_rvalid", a_rvalid, 1);
    chk("t3_a_rdata_old", a_rdata, 32'h5);
    idle(); cyc();
    step(1, RD, 14'h0030, '0, 0, 2'b00, '0, '0);
    chk("t3_a_rdata_new", a_rdata, 32'hABCD0123);
    idle(); cyc(); cyc();

    // Inactive encodings only: nothing issued, never a stall.
    for (int i = 0; i < 8; i++) begin
      a_valid = i[0]; b_valid = !i[0];
      a_mem_sig = i[1] ? 2'b11 : 2'b00; b_mem_sig = i[2] ? 2'b11 : 2'b00;
      a_addr = AW'($urandom); b_addr = AW'($urandom);
      a_wdata = $urandom; b_wdata = $urandom;
      #1;
      chk("t4_mem_sig", mem_sig, 0);
      chk("t4_ready", lanes_ready, 1);
      cyc();
      chk("t4_rvalid", {a_rvalid, b_rvalid}, 0);
    end
    idle(); cyc();

    // Reset while a B write is parked: the write must be lost.
    step(1, WR, 14'h0040, 32'h7, 0, 2'b00, '0, '0);
    step(1, WR, 14'h0041, 32'h12, 1, WR, 14'h0040, 32'h99);
    rst_n = 1'b0;
    idle(); #1;
    chk("t5_mem_sig", mem_sig, 0);
    chk("t5_ready", lanes_ready, 1);
    chk("t5_cnt", conflict_cnt, 0);
    cyc(); cyc();
    rst_n = 1'b1;
    cyc();
    step(1, RD, 14'h0040, '0, 0, 2'b00, '0, '0);
    chk("t5_old_data", a_rdata, 32'h7);
    idle(); cyc();

    // Counter saturation with back-to-back conflicts.
    for (int i = 0; i < 20; i++)
      step(1, 2'($urandom_range(1, 2)), AW'($urandom_range(0, 7)), $urandom,
           1, 2'($urandom_range(1, 2)), AW'($urandom_range(0, 7)), $urandom);
    idle(); cyc(); cyc();
    chk("t6_cnt_sat", conflict_cnt, 4'hF);

    // Randomized traffic over a small address window to provoke hazards.
    for (int i = 0; i < 600; i++)
      step(($urandom % 4) != 0, 2'($urandom), AW'($urandom_range(0, 7)), $urandom,
           ($urandom % 4) != 0, 2'($urandom), AW'($urandom_range(0, 7)), $urandom);
    idle();
    repeat (3) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
